// File: rtl/ex_pkg.sv
// Shared encodings for the MIPS execute stage: ALU opcodes, forwarding codes
// and the multiplier FSM state type.
package ex_pkg;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_NOR   = 4'd5;
  localparam logic [3:0] OP_SLT   = 4'd6;
  localparam logic [3:0] OP_SLTU  = 4'd7;
  localparam logic [3:0] OP_SLL   = 4'd8;
  localparam logic [3:0] OP_SRL   = 4'd9;
  localparam logic [3:0] OP_SRA   = 4'd10;
  localparam logic [3:0] OP_LUI   = 4'd11;
  localparam logic [3:0] OP_MULT  = 4'd12;
  localparam logic [3:0] OP_MULTU = 4'd13;
  localparam logic [3:0] OP_MFHI  = 4'd14;
  localparam logic [3:0] OP_MFLO  = 4'd15;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_EXE = 2'b10;
  localparam logic [1:0] FWD_MEM = 2'b01;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} mulState_t;

endpackage

// File: rtl/ex_stage_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle on operand
// magnitudes; the signed result is restored by negation on the final cycle.
module mul_iter
  import ex_pkg::*;
#(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic           is_signed,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] product
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  mulState_t      state, stateNext;
  logic [CW-1:0]  count;
  logic [2*W-1:0] acc, accNext, mcand;
  logic [W-1:0]   mplier, magA, magB;
  logic           negate;

  assign magA = (is_signed && a[W-1]) ? -a : a;
  assign magB = (is_signed && b[W-1]) ? -b : b;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  // NOTE: default assignment first keeps this block free of inferred latches.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (start) stateNext = BUSY;
      BUSY:    if (count == LAST) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
      negate <= 1'b0;
    end else if (state == IDLE && start) begin
      acc    <= '0;
      mcand  <= {{W{1'b0}}, magA};
      mplier <= magB;
      count  <= '0;
      negate <= is_signed && (a[W-1] ^ b[W-1]);
    end else if (state == BUSY) begin
      acc    <= accNext;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + 1'b1;
    end
  end

  assign accNext = acc + (mplier[0] ? mcand : '0);
  assign busy    = (state == BUSY);
  assign done    = busy && (count == LAST);
  // Valid only while done: it folds in the last partial product combinationally.
  assign product = negate ? -accNext : accNext;

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: operand forwarding, ALU, HI/LO with a multiply
// interlock, and the EX/MEM pipeline register.
module ex_stage
  import ex_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int REGW  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_valid,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic [WIDTH-1:0] imm,
  input  logic             alu_src,
  input  logic [1:0]       forward_a,
  input  logic [1:0]       forward_b,
  input  logic [WIDTH-1:0] wb_val,
  input  logic [REGW-1:0]  dest_reg,
  input  logic             reg_write,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             mem_stall,
  output logic             stall_out,
  output logic             exmem_valid,
  output logic             exmem_reg_write,
  output logic             exmem_mem_read,
  output logic             exmem_mem_write,
  output logic [WIDTH-1:0] exmem_result,
  output logic [WIDTH-1:0] exmem_store_data,
  output logic [REGW-1:0]  exmem_dest
);

  logic [WIDTH-1:0]   opA, opBFwd, opB, aluResult, hi, lo;
  logic [2*WIDTH-1:0] product;
  logic [4:0]         shamt;
  logic               isMul, isHiLo, mulBusy, mulDone, mulStart, interlock, writeValid;

  function automatic logic [WIDTH-1:0] fwdSel(input logic [1:0] code,
                                              input logic [WIDTH-1:0] regVal,
                                              input logic [WIDTH-1:0] exeVal,
                                              input logic [WIDTH-1:0] memVal);
    case (code)
      FWD_EXE: return exeVal;
      FWD_MEM: return memVal;
      default: return regVal;
    endcase
  endfunction

  assign opA    = fwdSel(forward_a, rs_val, exmem_result, wb_val);
  assign opBFwd = fwdSel(forward_b, rt_val, exmem_result, wb_val);
  assign opB    = alu_src ? imm : opBFwd;
  assign shamt  = opA[4:0];

  assign isMul      = (alu_op == OP_MULT) || (alu_op == OP_MULTU);
  assign isHiLo     = isMul || (alu_op == OP_MFHI) || (alu_op == OP_MFLO);
  assign interlock  = ex_valid && isHiLo && mulBusy;
  assign stall_out  = mem_stall || interlock;
  assign mulStart   = ex_valid && isMul && !mulBusy && !mem_stall;
  // Multiplies retire through HI/LO, so they leave a bubble in EX/MEM.
  assign writeValid = ex_valid && !isMul && !interlock;

  mul_iter #(.W(WIDTH)) u_mul (
    .clk      (clk),
    .reset    (reset),
    .start    (mulStart),
    .a        (opA),
    .b        (opB),
    .is_signed(alu_op == OP_MULT),
    .busy     (mulBusy),
    .done     (mulDone),
    .product  (product)
  );

  always_comb begin
    aluResult = '0;
    case (alu_op)
      OP_ADD:  aluResult = opA + opB;
      OP_SUB:  aluResult = opA - opB;
      OP_AND:  aluResult = opA & opB;
      OP_OR:   aluResult = opA | opB;
      OP_XOR:  aluResult = opA ^ opB;
      OP_NOR:  aluResult = ~(opA | opB);
      OP_SLT:  aluResult = {{(WIDTH-1){1'b0}}, $signed(opA) < $signed(opB)};
      OP_SLTU: aluResult = {{(WIDTH-1){1'b0}}, opA < opB};
      OP_SLL:  aluResult = opB << shamt;
      OP_SRL:  aluResult = opB >> shamt;
      OP_SRA:  aluResult = $signed(opB) >>> shamt;
      OP_LUI:  aluResult = {opB[WIDTH-17:0], 16'h0};
      OP_MFHI: aluResult = hi;
      OP_MFLO: aluResult = lo;
      default: aluResult = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (mulDone) begin
      hi <= product[2*WIDTH-1:WIDTH];
      lo <= product[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exmem_valid      <= 1'b0;
      exmem_reg_write  <= 1'b0;
      exmem_mem_read   <= 1'b0;
      exmem_mem_write  <= 1'b0;
      exmem_result     <= '0;
      exmem_store_data <= '0;
      exmem_dest       <= '0;
    end else if (!mem_stall) begin
      exmem_valid      <= writeValid;
      exmem_reg_write  <= writeValid && reg_write;
      exmem_mem_read   <= writeValid && mem_read;
      exmem_mem_write  <= writeValid && mem_write;
      exmem_result     <= aluResult;
      exmem_store_data <= opBFwd;
      exmem_dest       <= dest_reg;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed-vector bench for ex_stage: forwarding, ALU ops, multiply interlock,
// mem_stall hold and asynchronous reset of an in-flight multiply.
module tb_ex_stage;
  import ex_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid, alu_src, reg_write, mem_read, mem_write, mem_stall;
  logic [3:0]  alu_op;
  logic [31:0] rs_val, rt_val, imm, wb_val;
  logic [1:0]  forward_a, forward_b;
  logic [4:0]  dest_reg;
  logic        stall_out, exmem_valid, exmem_reg_write, exmem_mem_read, exmem_mem_write;
  logic [31:0] exmem_result, exmem_store_data;
  logic [4:0]  exmem_dest;

  int nAssert = 0;
  int nFail   = 0;

  ex_stage #(.WIDTH(32), .REGW(5)) dut (
    .clk             (clk),
    .reset           (reset),
    .ex_valid        (ex_valid),
    .alu_op          (alu_op),
    .rs_val          (rs_val),
    .rt_val          (rt_val),
    .imm             (imm),
    .alu_src         (alu_src),
    .forward_a       (forward_a),
    .forward_b       (forward_b),
    .wb_val          (wb_val),
    .dest_reg        (dest_reg),
    .reg_write       (reg_write),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_stall       (mem_stall),
    .stall_out       (stall_out),
    .exmem_valid     (exmem_valid),
    .exmem_reg_write (exmem_reg_write),
    .exmem_mem_read  (exmem_mem_read),
    .exmem_mem_write (exmem_mem_write),
    .exmem_result    (exmem_result),
    .exmem_store_data(exmem_store_data),
    .exmem_dest      (exmem_dest)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [31:0] immV, input logic src, input logic [1:0] fa,
                       input logic [1:0] fb, input logic [31:0] wb);
    ex_valid  = 1'b1;
    alu_op    = op;
    rs_val    = rs;
    rt_val    = rt;
    imm       = immV;
    alu_src   = src;
    forward_a = fa;
    forward_b = fb;
    wb_val    = wb;
    dest_reg  = 5'd3;
    reg_write = 1'b1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    #1;
  endtask

  task automatic idleIn;
    ex_valid = 1'b0;
    #1;
  endtask

  task automatic waitStall(output int cycles);
    cycles = 0;
    while (stall_out && cycles < 40) begin
      tick;
      cycles++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; mem_stall = 1'b0;
    issue(OP_ADD, 32'd1, 32'd1, 32'd0, 1'b0, FWD_REG, FWD_REG, 32'd0);
    ex_valid = 1'b0;
    tick;
    nAssert++;
    if ({exmem_valid, exmem_reg_write, exmem_mem_read, exmem_mem_write} !== 4'b0) begin
      nFail++; $display("FAIL reset_ctrl: got %b, expected 0000",
        {exmem_valid, exmem_reg_write, exmem_mem_read, exmem_mem_write});
    end
    nAssert++;
    if ({exmem_result, exmem_store_data, exmem_dest} !== 69'd0) begin
      nFail++; $display("FAIL reset_data: got %h %h %h, expected all 0",
        exmem_result, exmem_store_data, exmem_dest);
    end
    nAssert++;
    if (stall_out !== 1'b0) begin
      nFail++; $display("FAIL reset_stall: got %b, expected 0", stall_out);
    end
    reset = 1'b0;
    tick;
  endtask

  task automatic test_forward_exe;
    issue(OP_ADD, 32'd2, 32'd3, 32'd0, 1'b0, FWD_REG, FWD_REG, 32'd0);
    tick;
    nAssert++;
    if (exmem_result !== 32'd5 || exmem_valid !== 1'b1 || exmem_reg_write !== 1'b1 || exmem_dest !== 5'd3) begin
      nFail++; $display("FAIL add_basic: got %h v%b rw%b d%0d, expected 5 v1 rw1 d3",
        exmem_result, exmem_valid, exmem_reg_write, exmem_dest);
    end
    issue(OP_ADD, 32'd9, 32'd0, 32'd1, 1'b1, FWD_EXE, FWD_REG, 32'd0);
    tick;
    nAssert++;
    if (exmem_result !== 32'd6) begin
      nFail++; $display("FAIL fwd_exe: got %h, expected 6", exmem_result);
    end
  endtask

  task automatic test_forward_mem;
    issue(OP_ADD, 32'h100, 32'hDEAD, 32'd4, 1'b1, FWD_REG, FWD_MEM, 32'h1234);
    reg_write = 1'b0; mem_write = 1'b1;
    tick;
    nAssert++;
    if (exmem_result !== 32'h104) begin
      nFail++; $display("FAIL sw_addr: got %h, expected 104", exmem_result);
    end
    nAssert++;
    if (exmem_store_data !== 32'h1234) begin
      nFail++; $display("FAIL sw_data: got %h, expected 1234", exmem_store_data);
    end
    nAssert++;
    if (exmem_mem_write !== 1'b1 || exmem_reg_write !== 1'b0) begin
      nFail++; $display("FAIL sw_ctrl: got mw%b rw%b, expected mw1 rw0", exmem_mem_write, exmem_reg_write);
    end
  endtask

  task automatic test_alu;
    logic [3:0]  ops [12];
    logic [31:0] av  [12];
    logic [31:0] bv  [12];
    logic [31:0] ev  [12];
    logic [1:0]  fa  [12];
    ops = '{OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLTU, OP_SLL, OP_SRL, OP_SRA, OP_LUI, OP_ADD};
    av  = '{32'd3, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hFFFFFFFF,
            32'hFFFFFFFF, 32'd4, 32'd4, 32'h24, 32'd0, 32'hFFFFFFFF};
    bv  = '{32'd5, 32'hFF00FF00, 32'hFF00FF00, 32'hFF00FF00, 32'hFF00FF00, 32'd1,
            32'd1, 32'd1, 32'h80000000, 32'h80000000, 32'hABCD1234, 32'd2};
    ev  = '{32'hFFFFFFFE, 32'hF000F000, 32'hFFF0FFF0, 32'h0FF00FF0, 32'h000F000F, 32'd1,
            32'd0, 32'h10, 32'h08000000, 32'hF8000000, 32'h12340000, 32'd1};
    fa  = '{FWD_REG, FWD_REG, FWD_REG, FWD_REG, FWD_REG, FWD_REG,
            FWD_REG, FWD_REG, FWD_REG, FWD_REG, FWD_REG, 2'b11};
    for (int i = 0; i < 12; i++) begin
      issue(ops[i], av[i], bv[i], 32'd0, 1'b0, fa[i], FWD_REG, 32'h5555);
      tick;
      nAssert++;
      if (exmem_result !== ev[i]) begin
        nFail++; $display("FAIL alu_op%0d: got %h, expected %h", ops[i], exmem_result, ev[i]);
      end
    end
  endtask

  task automatic test_bubble;
    issue(OP_ADD, 32'd1, 32'd1, 32'd0, 1'b0, FWD_REG, FWD_REG, 32'd0);
    ex_valid = 1'b0; mem_read = 1'b1; mem_write = 1'b1;
    tick;
    nAssert++;
    if ({exmem_valid, exmem_reg_write, exmem_mem_read, exmem_mem_write} !== 4'b0) begin
      nFail++; $display("FAIL bubble: got %b, expected 0000",
        {exmem_valid, exmem_reg_write, exmem_mem_read, exmem_mem_write});
    end
  endtask

  task automatic test_mult_stall;
    int cycles;
    issue(OP_MULT, 32'hFFFFFFFE, 32'd3, 32'd0, 1'b0, FWD_REG, FWD_REG, 32'd0);
    nAssert++;
    if (stall_out !== 1'b0) begin
      nFail++; $display("FAIL mult_accept_stall: got %b, expected 0", stall_out);
    end
    tick;
    nAssert++;
    if (exmem_valid !== 1'b0) begin
      nFail++; $display("FAIL mult_bubble: got %b, expected 0", exmem_valid);
    end
    issue(OP_MFLO, 32'd0, 32'd0, 32'd0, 1'b0, FWD_REG, FWD_REG, 32'd0);
    waitStall(cycles);
    nAssert++;
    if (cycles != 32) begin
      nFail++; $display("FAIL mult_stall_len: got %0d, expected 32", cycles);
    end
    nAssert++;
    if (exmem_valid !== 1'b0) begin
      nFail++; $display("FAIL interlock_bubble: got %b, expected 0", exmem_valid);
    end
    tick;
    nAssert++;
    if (exmem_result !== 32'hFFFFFFFA || exmem_valid !== 1'b1) begin
      nFail++; $display("FAIL mult_lo: got %h v%b, expected fffffffa v1", exmem_result, exmem_valid);
    end
    issue(OP_MFHI, 32'd0, 32'd0, 32'd0, 1'b0, FWD_REG, FWD_REG, 32'd0);
    tick;
    nAssert++;
    if (exmem_result !== 32'hFFFFFFFF) begin
      nFail++; $display("FAIL mult_hi: got %h, expected ffffffff", exmem_result);
    end
  endtask

  task automatic test_back_to_back;
    int cycles;
    issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 1'b0, FWD_REG, FWD_REG, 32'd0);
    tick;
    issue(OP_ADD, 32'd7, 32'd8, 32'd0, 1'b0, FWD_REG, FWD_REG, 32'd0);
    nAssert++;
    if (stall_out !== 1'b0) begin
      nFail++; $display("FAIL add_while_busy_stall: got %b, expected 0", stall_out);
    end
    tick;
    nAssert++;
    if (exmem_result !== 32'd15 || exmem_valid !== 1'b1) begin
      nFail++; $display("FAIL add_while_busy: got %h v%b, expected f v1", exmem_result, exmem_valid);
    end
    issue(OP_MFHI, 32'd0, 32'd0, 32'd0, 1'b0, FWD_REG, FWD_REG, 32'd0);
    waitStall(cycles);
    nAssert++;
    if (cycles != 31) begin
      nFail++; $display("FAIL multu_stall_len: got %0d, expected 31", cycles);
    end
    tick;
    nAssert++;
    if (exmem_result !== 32'hFFFFFFFE) begin
      nFail++; $display("FAIL multu_hi: got %h, expected fffffffe", exmem_result);
    end
    issue(OP_MFLO, 32'd0, 32'd0, 32'd0, 1'b0, FWD_REG, FWD_REG, 32'd0);
    tick;
    nAssert++;
    if (exmem_result !== 32'd1) begin
      nFail++; $display("FAIL multu_lo: got %h, expected 1", exmem_result);
    end
  endtask

  task automatic test_mem_stall;
    int cycles;
    issue(OP_MULTU, 32'd5, 32'd7, 32'd0, 1'b0, FWD_REG, FWD_REG, 32'd0);
    tick;
    issue(OP_ADD, 32'd1, 32'd1, 32'd0, 1'b0, FWD_REG, FWD_REG, 32'd0);
    tick;
    issue(OP_MFLO, 32'd0, 32'd0, 32'd0, 1'b0, FWD_REG, FWD_REG, 32'd0);
    mem_stall = 1'b1;
    #1;
    nAssert++;
    if (stall_out !== 1'b1) begin
      nFail++; $display("FAIL memstall_out: got %b, expected 1", stall_out);
    end
    for (int i = 0; i < 3; i++) begin
      tick;
      nAssert++;
      if (exmem_result !== 32'd2 || exmem_valid !== 1'b1 || exmem_reg_write !== 1'b1) begin
        nFail++; $display("FAIL memstall_hold%0d: got %h v%b rw%b, expected 2 v1 rw1",
          i, exmem_result, exmem_valid, exmem_reg_write);
      end
    end
    mem_stall = 1'b0;
    #1;
    waitStall(cycles);
    nAssert++;
    if (cycles != 28) begin
      nFail++; $display("FAIL memstall_count_advance: got %0d, expected 28", cycles);
    end
    tick;
    nAssert++;
    if (exmem_result !== 32'd35) begin
      nFail++; $display("FAIL memstall_lo: got %h, expected 23", exmem_result);
    end
  endtask

  task automatic test_reset_mid_mul;
    issue(OP_MULTU, 32'hFFFF, 32'hFFFF, 32'd0, 1'b0, FWD_REG, FWD_REG, 32'd0);
    tick;
    idleIn;
    repeat (10) tick;
    issue(OP_MFHI, 32'd0, 32'd0, 32'd0, 1'b0, FWD_REG, FWD_REG, 32'd0);
    nAssert++;
    if (stall_out !== 1'b1) begin
      nFail++; $display("FAIL busy_before_reset: got %b, expected 1", stall_out);
    end
    reset = 1'b1;
    #1;
    nAssert++;
    if (stall_out !== 1'b0 || exmem_valid !== 1'b0 || exmem_result !== 32'd0) begin
      nFail++; $display("FAIL async_reset: got s%b v%b %h, expected s0 v0 0",
        stall_out, exmem_valid, exmem_result);
    end
    tick;
    reset = 1'b0;
    issue(OP_MFHI, 32'd0, 32'd0, 32'd0, 1'b0, FWD_REG, FWD_REG, 32'd0);
    nAssert++;
    if (stall_out !== 1'b0) begin
      nFail++; $display("FAIL mfhi_after_reset_stall: got %b, expected 0", stall_out);
    end
    tick;
    nAssert++;
    if (exmem_result !== 32'd0 || exmem_valid !== 1'b1) begin
      nFail++; $display("FAIL mfhi_after_reset: got %h v%b, expected 0 v1", exmem_result, exmem_valid);
    end
    issue(OP_MFLO, 32'd0, 32'd0, 32'd0, 1'b0, FWD_REG, FWD_REG, 32'd0);
    tick;
    nAssert++;
    if (exmem_result !== 32'd0) begin
      nFail++; $display("FAIL mflo_after_reset: got %h, expected 0", exmem_result);
    end
  endtask

  initial begin
    test_reset;
    test_forward_exe;
    test_forward_mem;
    test_alu;
    test_bubble;
    test_mult_stall;
    test_back_to_back;
    test_mem_stall;
    test_reset_mid_mul;
    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
